// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, almost flags,
// synchronous flush and overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for fall-through reads.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             wr_ok, rd_ok;

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_LEVEL));
  assign almost_full  = (count >= CW'(AF_LEVEL));

  // acceptance is decided on pre-edge flags, so a full FIFO still drains on wr+rd
  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr & full;
      underflow <= rd & empty;
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !clr && wr_ok) mem[wptr] <= din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout = mem[rptr];
`else
  // registered read port; holds across idle cycles and flushes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                dout <= '0;
    else if (!clr && rd_ok)  dout <= mem[rptr];
  end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;
  localparam int W = 8, D = 16, AF = 14, AE = 2;

  logic clk = 1'b0, rst = 1'b0, clr = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;
  logic [10:0] act_st;

  int total = 0, bad = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = '0;
  logic m_ovf = 1'b0, m_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .din(din), .rd(rd), .dout(dout),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  assign act_st = {count, empty, full, almost_empty, almost_full, overflow, underflow};

  function automatic logic [10:0] exp_status();
    int n = q.size();
    return {5'(n), n == 0, n == D, n <= AE, n >= AF, m_ovf, m_udf};
  endfunction

`ifdef SYNC_FIFO_FWFT_EN
  function automatic bit dout_care();
    return q.size() != 0;
  endfunction
  function automatic logic [W-1:0] exp_dout();
    return (q.size() != 0) ? q[0] : '0;
  endfunction
`else
  function automatic bit dout_care();
    return 1'b1;
  endfunction
  function automatic logic [W-1:0] exp_dout();
    return m_dout;
  endfunction
`endif

  // drive one cycle and advance the model with the pre-edge occupancy
  task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic c);
    bit f, e;
    wr = w; din = d; rd = r; clr = c;
    @(posedge clk);
    f = (q.size() == D);
    e = (q.size() == 0);
    if (c) begin
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      m_ovf = w && f;
      m_udf = r && e;
      if (r && !e) m_dout = q.pop_front();
      if (w && !f) q.push_back(d);
    end
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (act_st !== 11'b00000_1_0_1_0_0_0) begin
      bad++; $display("FAIL reset_status act=%b exp=%b", act_st, 11'b00000_1_0_1_0_0_0);
    end
`ifndef SYNC_FIFO_FWFT_EN
    total++;
    if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout act=%h exp=00", dout); end
`endif
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < D; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      total++;
      if (act_st !== exp_status()) begin
        bad++; $display("FAIL fill[%0d] act=%b exp=%b", i, act_st, exp_status());
      end
    end
    for (int i = 0; i < D; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      total++;
      if (act_st !== exp_status() || (dout_care() && dout !== exp_dout())) begin
        bad++; $display("FAIL drain[%0d] st=%b/%b dout=%h/%h", i, act_st, exp_status(), dout, exp_dout());
      end
`ifndef SYNC_FIFO_FWFT_EN
      total++;
      if (dout !== 8'(i)) begin bad++; $display("FAIL drain_order[%0d] act=%h exp=%h", i, dout, 8'(i)); end
`endif
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < D; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    total++;
    if (act_st !== exp_status() || overflow !== 1'b1 || count !== 5'd16) begin
      bad++; $display("FAIL ovf_pulse act=%b exp=%b", act_st, exp_status());
    end
    step(1'b0, '0, 1'b0, 1'b0);
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear act=%b exp=0", overflow); end
    // full with wr+rd: read proceeds, write dropped
    step(1'b1, 8'hAB, 1'b1, 1'b0);
    total++;
    if (act_st !== exp_status() || (dout_care() && dout !== exp_dout())) begin
      bad++; $display("FAIL full_wr_rd st=%b/%b dout=%h/%h", act_st, exp_status(), dout, exp_dout());
    end
    for (int i = 0; i < D - 1; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      total++;
      if (act_st !== exp_status() || (dout_care() && dout !== exp_dout()) || dout === 8'hAA) begin
        bad++; $display("FAIL ovf_drain[%0d] st=%b/%b dout=%h/%h", i, act_st, exp_status(), dout, exp_dout());
      end
    end
  endtask

  task automatic test_underflow();
    logic [W-1:0] held;
    held = dout;
    step(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (act_st !== exp_status() || underflow !== 1'b1) begin
      bad++; $display("FAIL udf_pulse act=%b exp=%b", act_st, exp_status());
    end
`ifndef SYNC_FIFO_FWFT_EN
    total++;
    if (dout !== held) begin bad++; $display("FAIL udf_dout_hold act=%h exp=%h", dout, held); end
`endif
    step(1'b1, 8'h55, 1'b1, 1'b0);
    total++;
    if (act_st !== exp_status() || count !== 5'd1 || underflow !== 1'b1) begin
      bad++; $display("FAIL empty_wr_rd act=%b exp=%b", act_st, exp_status());
    end
    step(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (act_st !== exp_status() || underflow !== 1'b0) begin
      bad++; $display("FAIL udf_read_status act=%b exp=%b", act_st, exp_status());
    end
`ifndef SYNC_FIFO_FWFT_EN
    total++;
    if (dout !== 8'h55) begin bad++; $display("FAIL udf_read_data act=%h exp=55", dout); end
`endif
  endtask

  task automatic test_wrap();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      total++;
      if (act_st !== exp_status() || count !== 5'd8 || (dout_care() && dout !== exp_dout())) begin
        bad++; $display("FAIL wrap[%0d] st=%b/%b dout=%h/%h", i, act_st, exp_status(), dout, exp_dout());
      end
    end
  endtask

  task automatic test_clr();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    total++;
    if (act_st !== exp_status() || count !== 5'd0 || empty !== 1'b1) begin
      bad++; $display("FAIL clr_status act=%b exp=%b", act_st, exp_status());
    end
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    total++;
    if (dout !== 8'h77) begin bad++; $display("FAIL clr_first_data act=%h exp=77", dout); end
`endif
    total++;
    if (act_st !== exp_status()) begin bad++; $display("FAIL clr_after act=%b exp=%b", act_st, exp_status()); end
  endtask

  task automatic test_random();
    bit w, r, c;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < ((i / 50) % 2 ? 30 : 70));
      r = ($urandom_range(0, 99) < ((i / 50) % 2 ? 70 : 30));
      c = ($urandom_range(0, 59) == 0);
      step(w, 8'($urandom), r, c);
      total++;
      if (act_st !== exp_status() || (dout_care() && dout !== exp_dout())) begin
        bad++; $display("FAIL rand[%0d] st=%b/%b dout=%h/%h", i, act_st, exp_status(), dout, exp_dout());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    wr = 1'b1; rd = 1'b1; din = 8'h99;
    #2 rst = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
    total++;
    if (act_st !== exp_status()) begin bad++; $display("FAIL async_rst act=%b exp=%b", act_st, exp_status()); end
`ifndef SYNC_FIFO_FWFT_EN
    total++;
    if (dout !== 8'h00) begin bad++; $display("FAIL async_rst_dout act=%h exp=00", dout); end
`endif
    wr = 1'b0; rd = 1'b0;
    @(negedge clk); rst = 1'b1;
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (act_st !== exp_status() || (dout_care() && dout !== exp_dout())) begin
      bad++; $display("FAIL post_rst st=%b/%b dout=%h/%h", act_st, exp_status(), dout, exp_dout());
    end
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    total++;
    if (empty !== 1'b0 || dout !== 8'h3C) begin
      bad++; $display("FAIL fwft_head empty=%b dout=%h exp 0/3c", empty, dout);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL fwft_pop empty=%b exp=1", empty); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_clr();
    test_random();
    test_async_reset();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
